stream_llr_interleaver: RTL and testbench

Streaming ping-pong interleaver/deinterleaver for turbo decoding. It sits directly downstream of `stream_bcjr_max_product`, whose `out_valid`/`LLR_D` stream feeds it, and produces the permuted frame for the second constituent decoder. It captures one symbol of `BITS_PER_SYMBOL` LLR words per input beat into one of two frame banks. It reads the completed bank out in permuted order under a valid/ready handshake, with a per-bit hard decision attached to each beat.

---
 rtl/stream_llr_interleaver_if.sv | 26 ++
 rtl/stream_llr_interleaver.sv | 191 +++++++++++++++++++
 tb/tb_stream_llr_interleaver.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_llr_interleaver_if.sv
// Handshake/bus bundle for stream_llr_interleaver: input beat, permuted output beat, status.
// Ports: in_valid/LLRIn (input beat, no ready), out_valid/out_ready/LLROut/out_hard/out_last (output beat),
//        overflow (sticky drop flag). master = upstream/downstream side, slave = interleaver side.
interface stream_llr_interleaver_if #(
  parameter int BITS            = 32,
  parameter int BITS_PER_SYMBOL = 2
);
  logic                       in_valid;
  logic [BITS-1:0]            LLRIn  [BITS_PER_SYMBOL];
  logic                       out_ready;
  logic                       out_valid;
  logic [BITS-1:0]            LLROut [BITS_PER_SYMBOL];
  logic [BITS_PER_SYMBOL-1:0] out_hard;
  logic                       out_last;
  logic                       overflow;

  modport master (
    output in_valid, LLRIn, out_ready,
    input  out_valid, LLROut, out_hard, out_last, overflow
  );

  modport slave (
    input  in_valid, LLRIn, out_ready,
    output out_valid, LLROut, out_hard, out_last, overflow
  );
endinterface

// File: rtl/stream_llr_interleaver.sv
// Ping-pong frame interleaver: writes symbols in arrival order, reads the completed bank in permuted order.
// Latency: frame complete at edge E -> first out_valid after edge E+1; then one beat per cycle.
// Backpressure: output holds under out_valid && !out_ready; input has none, a beat into a still-full bank is dropped (overflow).
// Ports: clk, reset (async, active-high), bus (slave modport of stream_llr_interleaver_if).
module stream_llr_interleaver #(
  parameter int BITS            = 32,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int SYMBOLS         = 5,
  parameter int PERM [SYMBOLS]  = '{1, 3, 0, 4, 2},
  parameter bit DEINTERLEAVE    = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  stream_llr_interleaver_if.slave  bus
);

  localparam int IDX_W = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMBOLS - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  // Read address of output beat k: PERM[k] forward, or the j with PERM[j]==k when deinterleaving.
  function automatic int rd_addr_of(input int k);
    int r;
    r = PERM[k];
    if (DEINTERLEAVE) begin
      for (int j = 0; j < SYMBOLS; j++) begin
        if (PERM[j] == k) r = j;
      end
    end
    return r;
  endfunction

  logic [IDX_W-1:0] rd_addr_tab [SYMBOLS];
  for (genvar k = 0; k < SYMBOLS; k++) begin : g_addr
    localparam int ADDR = rd_addr_of(k);
    assign rd_addr_tab[k] = IDX_W'(ADDR);
  end

  // Frame storage; contents are don't-care until a full flag covers them, so no reset.
  logic [BITS-1:0] mem_q [2][SYMBOLS][BITS_PER_SYMBOL];

  state_t           state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic [BITS-1:0]  llr_out_q [BITS_PER_SYMBOL];
  logic [BITS-1:0]  llr_out_d [BITS_PER_SYMBOL];

  logic             handshake;
  logic             rd_done;
  logic             wr_blocked;
  logic             wr_en;
  logic             load_en;
  logic             load_bank;
  logic [IDX_W-1:0] load_idx;

  assign handshake = out_valid_q && bus.out_ready;
  // Final beat of the bank accepted: the bank is released on this edge.
  assign rd_done   = (state_q == S_READ) && handshake && (rd_idx_q == LAST_IDX);

  // ---------------- read FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- read FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (full_q[rd_bank_q]) state_d = S_READ;
      S_READ:  if (rd_done && !full_q[~rd_bank_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- read FSM: outputs / read datapath ----------------
  always_comb begin
    load_en     = 1'b0;
    load_bank   = rd_bank_q;
    load_idx    = '0;
    out_valid_d = out_valid_q;
    rd_idx_d    = rd_idx_q;
    rd_bank_d   = rd_bank_q;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          load_en     = 1'b1;
          out_valid_d = 1'b1;
          rd_idx_d    = '0;
        end
      end
      S_READ: begin
        if (handshake) begin
          if (rd_idx_q != LAST_IDX) begin
            load_en  = 1'b1;
            load_idx = rd_idx_q + 1'b1;
            rd_idx_d = load_idx;
          end else begin
            rd_bank_d = ~rd_bank_q;
            rd_idx_d  = '0;
            // Other bank already waiting: chain straight into it without a bubble.
            if (full_q[~rd_bank_q]) begin
              load_en   = 1'b1;
              load_bank = ~rd_bank_q;
            end else begin
              out_valid_d = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase

    for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
      llr_out_d[b] = llr_out_q[b];
      if (load_en) llr_out_d[b] = mem_q[load_bank][rd_addr_tab[load_idx]][b];
    end
  end

  // ---------------- write side ----------------
  always_comb begin
    // A full bank accepts a write only when it is being released on this same edge.
    wr_blocked = full_q[wr_bank_q] && !(rd_done && (rd_bank_q == wr_bank_q));
    wr_en      = bus.in_valid && !wr_blocked;
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    full_d     = full_q;
    overflow_d = overflow_q;

    // Release first, then completion, so both land when they hit different banks.
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_en) begin
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (bus.in_valid && wr_blocked) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
        mem_q[wr_bank_q][wr_idx_q][b] <= bus.LLRIn[b];
      end
    end
  end

  // ---------------- control / output registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int b = 0; b < BITS_PER_SYMBOL; b++) llr_out_q[b] <= '0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      for (int b = 0; b < BITS_PER_SYMBOL; b++) llr_out_q[b] <= llr_out_d[b];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.LLROut    = llr_out_q;
  assign bus.out_last  = out_valid_q && (rd_idx_q == LAST_IDX);
  assign bus.overflow  = overflow_q;

  // Hard decision: strictly positive only, so both signed zeros map to 0.
  for (genvar b = 0; b < BITS_PER_SYMBOL; b++) begin : g_hard
    assign bus.out_hard[b] = ~llr_out_q[b][BITS-1] & (|llr_out_q[b][BITS-2:0]);
  end

endmodule

// File: tb/tb_stream_llr_interleaver.sv
module tb_stream_llr_interleaver;

  localparam int BITS = 32;
  localparam int BPS  = 2;
  localparam int SYM  = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_llr_interleaver_if #(.BITS(BITS), .BITS_PER_SYMBOL(BPS)) bus0 ();
  stream_llr_interleaver_if #(.BITS(BITS), .BITS_PER_SYMBOL(BPS)) bus1 ();

  stream_llr_interleaver #(.BITS(BITS), .BITS_PER_SYMBOL(BPS), .SYMBOLS(SYM), .DEINTERLEAVE(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  stream_llr_interleaver #(.BITS(BITS), .BITS_PER_SYMBOL(BPS), .SYMBOLS(SYM), .DEINTERLEAVE(1'b1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [31:0] l0;
    logic [31:0] l1;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Output symbol order, worked out by hand from PERM = {1,3,0,4,2} and its inverse.
  int ORD0 [SYM] = '{1, 3, 0, 4, 2};
  int ORD1 [SYM] = '{2, 0, 4, 1, 3};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt    [2] = '{0, 0};
  int first_v [2] = '{-1, -1};
  int last_v  [2] = '{-1, -1};
  logic        stl [2] = '{1'b0, 1'b0};
  logic [31:0] h0  [2];
  logic [31:0] h1  [2];
  logic        hl  [2];
  logic        rnd_en = 1'b0;

  logic [31:0] f0 [SYM];
  logic [31:0] f1 [SYM];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic hard_of(input logic [31:0] x);
    return (x[31] == 1'b0) && (x[30:0] != 31'd0);
  endfunction

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b);
    bus0.in_valid = v; bus0.LLRIn[0] = a; bus0.LLRIn[1] = b;
    bus1.in_valid = v; bus1.LLRIn[0] = a; bus1.LLRIn[1] = b;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last beat (and gap) is sampled.
  task automatic send_frame(input logic [31:0] a [SYM], input logic [31:0] b [SYM], input bit kept, input int gap);
    exp_t e;
    if (kept) begin
      for (int k = 0; k < SYM; k++) begin
        e.l0 = a[ORD0[k]]; e.l1 = b[ORD0[k]]; e.last = (k == SYM - 1); q0.push_back(e);
        e.l0 = a[ORD1[k]]; e.l1 = b[ORD1[k]]; e.last = (k == SYM - 1); q1.push_back(e);
      end
    end
    for (int s = 0; s < SYM; s++) begin
      set_in(1'b1, a[s], b[s]);
      @(posedge clk); #1;
    end
    set_in(1'b0, 32'h0, 32'h0);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (((q0.size() != 0) || (q1.size() != 0)) && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", q0.size() + q1.size(), 0);
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid0"}, bus0.out_valid, 0);
    chk({tag, "_last0"},  bus0.out_last, 0);
    chk({tag, "_ovf0"},   bus0.overflow, 0);
    chk({tag, "_llr0_0"}, bus0.LLROut[0], 0);
    chk({tag, "_llr0_1"}, bus0.LLROut[1], 0);
    chk({tag, "_hard0"},  bus0.out_hard, 0);
    chk({tag, "_valid1"}, bus1.out_valid, 0);
    chk({tag, "_ovf1"},   bus1.overflow, 0);
    chk({tag, "_llr1_0"}, bus1.LLROut[0], 0);
  endtask

  task automatic mon(input int id, input logic v, input logic r, input logic [31:0] l0,
                     input logic [31:0] l1, input logic [1:0] hd, input logic lst);
    exp_t e;
    if (v) begin
      vcnt[id]++;
      if (first_v[id] < 0) first_v[id] = cyc;
      last_v[id] = cyc;
    end
    if (v && stl[id]) begin
      chk($sformatf("dut%0d_hold_llr0", id), l0, h0[id]);
      chk($sformatf("dut%0d_hold_llr1", id), l1, h1[id]);
      chk($sformatf("dut%0d_hold_last", id), lst, hl[id]);
    end
    if (v && r) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_beat: got beat %h/%h want none", id, l0, l1);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("dut%0d_llr0", id), l0, e.l0);
        chk($sformatf("dut%0d_llr1", id), l1, e.l1);
        chk($sformatf("dut%0d_hard0", id), hd[0], hard_of(e.l0));
        chk($sformatf("dut%0d_hard1", id), hd[1], hard_of(e.l1));
        chk($sformatf("dut%0d_last", id), lst, e.last);
      end
    end
    stl[id] = v && !r;
    h0[id]  = l0;
    h1[id]  = l1;
    hl[id]  = lst;
  endtask

  // Monitor: samples on the falling edge, away from the register updates.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      stl[0] = 1'b0;
      stl[1] = 1'b0;
    end else begin
      mon(0, bus0.out_valid, bus0.out_ready, bus0.LLROut[0], bus0.LLROut[1], bus0.out_hard, bus0.out_last);
      mon(1, bus1.out_valid, bus1.out_ready, bus1.LLROut[0], bus1.LLROut[1], bus1.out_hard, bus1.out_last);
    end
  end

  // Random out_ready, applied after the main process may have switched it off.
  always @(posedge clk) begin
    #2;
    if (rnd_en) set_ready(1'($urandom_range(0, 1)));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1'b0, 32'h0, 32'h0);
    set_ready(1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals("rst_init");
    reset = 1'b0;
    @(posedge clk); #1;

    // Single frame, forward and inverse permutation, latency check.
    f0 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    f1 = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000};
    send_frame(f0, f1, 1'b1, 0);
    @(negedge clk);
    chk("lat_edge1_valid0", bus0.out_valid, 0);
    chk("lat_edge1_valid1", bus1.out_valid, 0);
    @(negedge clk);
    chk("lat_edge2_valid0", bus0.out_valid, 1);
    chk("lat_edge2_valid1", bus1.out_valid, 1);
    @(posedge clk); #1;
    wait_drain(50);

    // 25 back-to-back frames with out_ready held high.
    first_v[0] = -1; first_v[1] = -1;
    vcnt[0] = 0; vcnt[1] = 0;
    for (int f = 0; f < 25; f++) begin
      for (int s = 0; s < SYM; s++) begin
        f0[s] = 32'h41000000 + 32'(f * 256 + s);
        f1[s] = (s % 2 == 1) ? (32'h80000000 | 32'(f * 16 + s + 1)) : 32'(f * 16 + s);
      end
      send_frame(f0, f1, 1'b1, 0);
    end
    wait_drain(100);
    chk("b2b_valid_cnt0", vcnt[0], 125);
    chk("b2b_valid_cnt1", vcnt[1], 125);
    chk("b2b_span0", last_v[0] - first_v[0] + 1, 125);
    chk("b2b_span1", last_v[1] - first_v[1] + 1, 125);
    chk("b2b_ovf0", bus0.overflow, 0);
    chk("b2b_ovf1", bus1.overflow, 0);

    // Random out_ready toggling with gapped input.
    rnd_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < SYM; s++) begin
        f0[s] = 32'h30000000 + 32'(f * 32 + s);
        f1[s] = (s == 2) ? 32'h80000000 : (32'hC0000000 + 32'(f * 8 + s));
      end
      send_frame(f0, f1, 1'b1, 15);
    end
    wait_drain(400);
    rnd_en = 1'b0;
    set_ready(1'b1);
    chk("rnd_ovf0", bus0.overflow, 0);
    chk("rnd_ovf1", bus1.overflow, 0);

    // Stall while three frames arrive: two buffered, third dropped.
    set_ready(1'b0);
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < SYM; s++) begin
        f0[s] = 32'h50000000 + 32'(f * 16 + s);
        f1[s] = 32'hD0000000 + 32'(f * 16 + s);
      end
      send_frame(f0, f1, (f < 2), 0);
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_ovf0", bus0.overflow, 1);
    chk("stall_ovf1", bus1.overflow, 1);
    chk("stall_valid0", bus0.out_valid, 1);
    set_ready(1'b1);
    wait_drain(100);

    // Reset pulse after three beats of a partial frame.
    for (int s = 0; s < 3; s++) begin
      set_in(1'b1, 32'h7000_0000 + 32'(s), 32'h7100_0000 + 32'(s));
      @(posedge clk); #1;
    end
    set_in(1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #2;
    chk_reset_vals("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < SYM; s++) begin
      f0[s] = (s % 2 == 1) ? 32'h80000000 : 32'h00000000;
      f1[s] = (s % 2 == 1) ? 32'h00000000 : 32'h80000000;
    end
    send_frame(f0, f1, 1'b1, 0);
    wait_drain(50);
    chk("zero_hard0", bus0.out_hard, 0);
    chk("zero_hard1", bus1.out_hard, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
